// File: rtl/conv_maxpool.sv
// Streaming 2x2 stride-2 max-pool over a raster-order sample stream.
// Even rows park horizontal pair maxima in a half-width line buffer; odd rows finish each window.
module conv_maxpool #(
    parameter int BW = 8,
    parameter int DW = 72,
    parameter int DH = 128,
    parameter int RL = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_valid,
    input  logic          i_data_last,
    input  logic [BW-1:0] i_data,
    output logic          o_data_valid,
    output logic          o_data_last,
    output logic [BW-1:0] o_data,
    output logic          o_frame_err
);

    localparam int CW = $clog2(DW);
    localparam int RW = $clog2(DH);
    localparam logic [CW-1:0] COL_LAST = CW'(DW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DH - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic signed [BW-1:0] h_reg;
    logic signed [BW-1:0] hmax;
    logic signed [BW-1:0] pmax;
    logic signed [BW-1:0] pooled;
    logic signed [BW-1:0] lb_rd;
    logic [BW-1:0]        lbuf [DW/2];
    logic [CW-2:0]        lb_idx;
    logic                 at_end;

    assign lb_idx = col[CW-1:1];
    assign at_end = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        lb_rd  = $signed(lbuf[lb_idx]);
        hmax   = ($signed(i_data) > h_reg) ? $signed(i_data) : h_reg;
        pmax   = (lb_rd > hmax) ? lb_rd : hmax;
        pooled = pmax;
        if (RL != 0 && pmax[BW-1]) begin
            pooled = '0;
        end
    end

    // Line buffer is deliberately not reset: every slot is rewritten on the even row before use.
    always_ff @(posedge i_clk) begin
        if (i_data_valid && col[0] && !row[0]) begin
            lbuf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col          <= '0;
            row          <= '0;
            h_reg        <= '0;
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            o_data       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            o_frame_err  <= 1'b0;
            if (i_data_valid) begin
                if (!col[0]) begin
                    h_reg <= i_data;
                end
                if (col[0] && row[0]) begin
                    o_data_valid <= 1'b1;
                    o_data       <= pooled;
                end
                // Any frame boundary, early or missing, resynchronises the window grid to (0,0).
                if (i_data_last || at_end) begin
                    col         <= '0;
                    row         <= '0;
                    o_data_last <= i_data_last && at_end;
                    o_frame_err <= i_data_last != at_end;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: small 4x4 instances (ReLU off/on) for directed vectors,
// a default-size instance for full-frame, gap, reset and back-to-back streams.
`timescale 1ns/1ps
module tb_conv_maxpool;

    typedef struct {
        logic       v;
        logic       l;
        logic       e;
        logic [7:0] d;
        time        t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       s_valid, s_last, b_valid, b_last;
    logic [7:0] s_data, b_data;
    logic       s_ov, s_ol, s_oe, r_ov, r_ol, r_oe, b_ov, b_ol, b_oe;
    logic [7:0] s_od, r_od, b_od;

    exp_t qs[$];
    exp_t qr[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   nb_exp = 0;
    int   nb_seen = 0;

    logic [7:0] sp  [16];
    logic [7:0] se0 [4];
    logic [7:0] se1 [4];
    logic [7:0] img [128][72];
    logic [7:0] win [64][36];

    conv_maxpool #(.BW(8), .DW(4), .DH(4), .RL(0)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_data_valid(s_valid), .i_data_last(s_last), .i_data(s_data),
        .o_data_valid(s_ov), .o_data_last(s_ol), .o_data(s_od), .o_frame_err(s_oe)
    );

    conv_maxpool #(.BW(8), .DW(4), .DH(4), .RL(1)) dut_r (
        .i_clk(clk), .i_rst(rst), .i_data_valid(s_valid), .i_data_last(s_last), .i_data(s_data),
        .o_data_valid(r_ov), .o_data_last(r_ol), .o_data(r_od), .o_frame_err(r_oe)
    );

    conv_maxpool dut_b (
        .i_clk(clk), .i_rst(rst), .i_data_valid(b_valid), .i_data_last(b_last), .i_data(b_data),
        .o_data_valid(b_ov), .o_data_last(b_ol), .o_data(b_od), .o_frame_err(b_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual still running, required finish before 2ms");
        $fatal(1, "[TB] timeout");
    end

    function automatic exp_t mk(input logic v, input logic l, input logic e, input logic [7:0] d);
        exp_t x;
        x.v = v;
        x.l = l;
        x.e = e;
        x.d = d;
        x.t = 0;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic checkEvent(input string name, input exp_t ex, input logic v, input logic l,
                              input logic e, input logic [7:0] d);
        logic [7:0] dreq;
        dreq = ex.v ? ex.d : d;
        checkOutput({name, "_beat"}, {53'd0, v, l, e, d}, {53'd0, ex.v, ex.l, ex.e, dreq});
        checkOutput({name, "_time"}, 64'($time), 64'(ex.t));
    endtask

    // Output events land one clock after the capturing edge, sampled on the following falling edge.
    task automatic applyStimulus(input bit big, input logic v, input logic l, input logic [7:0] d,
                                 input bit ev, input exp_t es, input logic [7:0] odr);
        s_valid = big ? 1'b0 : v;
        s_last  = big ? 1'b0 : l;
        s_data  = big ? 8'd0 : d;
        b_valid = big ? v : 1'b0;
        b_last  = big ? l : 1'b0;
        b_data  = big ? d : 8'd0;
        if (ev) begin
            es.t = $time + 14;
            if (big) begin
                qb.push_back(es);
                if (es.v) nb_exp++;
            end else begin
                qs.push_back(es);
                es.d = odr;
                qr.push_back(es);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        b_valid = 1'b0;
        b_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic smallFrame(input bit with_last);
        for (int i = 0; i < 16; i++) begin
            int r;
            int c;
            int w;
            bit odd;
            bit endb;
            r    = i / 4;
            c    = i % 4;
            w    = (r / 2) * 2 + c / 2;
            odd  = (r % 2 == 1) && (c % 2 == 1);
            endb = (i == 15);
            applyStimulus(1'b0, 1'b1, with_last && endb, sp[i], odd,
                          mk(1'b1, with_last && endb, !with_last && endb, se0[w]), se1[w]);
        end
    endtask

    task automatic bigFrame(input bit gaps, input int stop, input bit with_last);
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 72; c++)
                img[r][c] = 8'($urandom);
        for (int wr = 0; wr < 64; wr++) begin
            for (int wc = 0; wc < 36; wc++) begin
                logic signed [7:0] m;
                logic signed [7:0] x;
                m = img[2*wr][2*wc];
                x = img[2*wr][2*wc+1];   if (x > m) m = x;
                x = img[2*wr+1][2*wc];   if (x > m) m = x;
                x = img[2*wr+1][2*wc+1]; if (x > m) m = x;
                win[wr][wc] = m;
            end
        end
        for (int i = 0; i < stop; i++) begin
            int r;
            int c;
            bit odd;
            bit endb;
            r    = i / 72;
            c    = i % 72;
            odd  = (r % 2 == 1) && (c % 2 == 1);
            endb = (i == 72 * 128 - 1);
            if (gaps && $urandom_range(1, 0) == 1) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, mk(1'b0, 1'b0, 1'b0, 8'd0), 8'd0);
            end
            applyStimulus(1'b1, 1'b1, with_last && endb, img[r][c], odd,
                          mk(1'b1, with_last && endb, !with_last && endb, win[r/2][c/2]), 8'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (s_ov || s_oe)) begin
            if (qs.size() == 0) checkOutput("small_extra", {53'd0, s_ov, s_ol, s_oe, s_od}, 64'd0);
            else checkEvent("small", qs.pop_front(), s_ov, s_ol, s_oe, s_od);
        end
    end

    always @(negedge clk) begin
        if (!rst && (r_ov || r_oe)) begin
            if (qr.size() == 0) checkOutput("relu_extra", {53'd0, r_ov, r_ol, r_oe, r_od}, 64'd0);
            else checkEvent("relu", qr.pop_front(), r_ov, r_ol, r_oe, r_od);
        end
    end

    always @(negedge clk) begin
        if (!rst && (b_ov || b_oe)) begin
            if (b_ov) nb_seen++;
            if (qb.size() == 0) checkOutput("big_extra", {53'd0, b_ov, b_ol, b_oe, b_od}, 64'd0);
            else checkEvent("big", qb.pop_front(), b_ov, b_ol, b_oe, b_od);
        end
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'd0;
        b_valid = 1'b0;
        b_last  = 1'b0;
        b_data  = 8'd0;
        #3;
        checkOutput("reset_small", {53'd0, s_ov, s_ol, s_oe, s_od}, 64'd0);
        checkOutput("reset_relu", {53'd0, r_ov, r_ol, r_oe, r_od}, 64'd0);
        checkOutput("reset_big", {53'd0, b_ov, b_ol, b_oe, b_od}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) sp[i] = 8'(i);
        se0 = '{8'd5, 8'd7, 8'd13, 8'd15};
        se1 = '{8'd5, 8'd7, 8'd13, 8'd15};
        $display("[TB] ramp frame 4x4");
        smallFrame(1'b1);
        idle(2);

        $display("[TB] signed windows");
        sp  = '{8'h80, 8'hFD, 8'h7F, 8'h80, 8'hF9, 8'h9C, 8'h00, 8'h05,
                8'h01, 8'h02, 8'hFB, 8'hFF, 8'h03, 8'h04, 8'hF7, 8'hFE};
        se0 = '{8'hFD, 8'h7F, 8'h04, 8'hFF};
        se1 = '{8'h00, 8'h7F, 8'h04, 8'h00};
        smallFrame(1'b1);
        idle(2);

        for (int i = 0; i < 16; i++) sp[i] = 8'(i);
        se0 = '{8'd5, 8'd7, 8'd13, 8'd15};
        se1 = '{8'd5, 8'd7, 8'd13, 8'd15};

        $display("[TB] early last at (1,1), then ramp with no idle");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, i == 5, 8'(i + 1), i == 5, mk(1'b1, 1'b0, 1'b1, 8'd6), 8'd6);
        end
        smallFrame(1'b1);
        idle(2);

        $display("[TB] early last at (0,2), then ramp");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, i == 2, 8'(i + 1), i == 2, mk(1'b0, 1'b0, 1'b1, 8'd0), 8'd0);
        end
        smallFrame(1'b1);
        idle(2);

        $display("[TB] missing last, then ramp");
        smallFrame(1'b0);
        smallFrame(1'b1);
        idle(2);

        $display("[TB] full frame with random valid gaps");
        bigFrame(1'b1, 72 * 128, 1'b1);
        idle(2);

        $display("[TB] reset pulse at row 37 col 10, then fresh frame");
        bigFrame(1'b0, 37 * 72 + 10, 1'b1);
        idle(2);
        rst = 1'b1;
        #2;
        checkOutput("reset_mid_big", {53'd0, b_ov, b_ol, b_oe, b_od}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bigFrame(1'b0, 72 * 128, 1'b1);
        idle(2);

        $display("[TB] two back-to-back frames");
        bigFrame(1'b0, 72 * 128, 1'b1);
        bigFrame(1'b0, 72 * 128, 1'b1);
        idle(4);

        checkOutput("small_pending", 64'(qs.size()), 64'd0);
        checkOutput("relu_pending", 64'(qr.size()), 64'd0);
        checkOutput("big_pending", 64'(qb.size()), 64'd0);
        checkOutput("big_output_count", 64'(nb_seen), 64'(nb_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_maxpool.md
# conv_maxpool

Streaming 2x2, stride-2 max-pooling stage placed directly downstream of `conv_img`. It consumes the convolution output stream in raster order (`o_data_valid`/`o_data_last`/`o_data` of `conv_img`), with no backpressure. It emits one signed maximum per non-overlapping 2x2 window, again in raster order, with an optional ReLU clamp. An even-row line buffer of DW/2 entries holds partial maxima, so the block needs no frame storage.

## Interface
- `BW`, 8: sample bit width, two's complement.
- `DW`, 72: input image width in samples; must be even.
- `DH`, 128: input image height in rows; must be even.
- `RL`, 0: 1 = clamp each pooled result to `max(result, 0)` (ReLU); 0 = pass the result unchanged.
- `i_clk`  in  1  clock; the only clock.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_data_valid`  in  1  input beat strobe.
- `i_data_last`  in  1  marks the final beat of the input frame; qualified by `i_data_valid`.
- `i_data`  in  BW  signed input sample.
- `o_data_valid`  out  1  pooled output strobe.
- `o_data_last`  out  1  final pooled output of the frame.
- `o_data`  out  BW  signed pooled sample.
- `o_frame_err`  out  1  one-cycle pulse on a framing mismatch.

## Operation
- Counters:
  - `col` runs 0..DW-1 and advances only on a valid beat.
  - `row` runs 0..DH-1 and advances when `col` wraps.
  - Both reset to 0.
- Horizontal pair:
  - On even `col`, latch the sample into `h_reg`.
  - On odd `col`, form `hmax = max(h_reg, i_data)` using a signed comparison.
- Even `row`, odd `col`: write `hmax` to `lbuf[col>>1]`. No output is produced.
- Odd `row`, odd `col`: compute `pmax = max(hmax, lbuf[col>>1])`, apply the ReLU if `RL`=1, and register the result to `o_data` with `o_data_valid`=1.
- `lbuf` has DW/2 entries of BW bits each. It may be a register array or inferred RAM with a 1-cycle read, provided output latency is unchanged. `lbuf` is not cleared by reset; it is always written on the even row before it is read.
- All comparisons are performed at full BW width. No arithmetic is done, so overflow is impossible. Ties select either operand, which is equal by definition.
- Frame end, normal case: `i_data_last` arrives with `row`=DH-1 and `col`=DW-1.
  - `o_data_last`=1 with that beat's output.
  - Counters return to 0.
- Premature last: `i_data_last` arrives at any other position.
  - Counters return to 0 and `o_frame_err` pulses.
  - If the beat is at an odd-row, odd-column position, its output is still emitted, but with `o_data_last`=0.
  - The partial window is discarded.
- Missing last: a beat at (DH-1, DW-1) arrives without `i_data_last`.
  - The output is emitted with `o_data_last`=0, `o_frame_err` pulses, and counters wrap to 0.
- Gaps: invalid cycles (`i_data_valid`=0) anywhere in the stream are ignored; state holds.
- Output count per well-formed frame is (DW/2)*(DH/2), which is 2304 with the default parameters.

## Timing
- Reset values: `o_data_valid`=0, `o_data_last`=0, `o_data`=0, `o_frame_err`=0, `col`=0, `row`=0, `h_reg`=0.
- Reset is asynchronous and may assert mid-frame. Outputs clear immediately. The first valid beat after deassertion is treated as (0,0).
- Latency: the output appears 1 clock after the input beat that completes the window (odd row, odd column).
- Output pulses:
  - `o_data_valid` is a 1-cycle pulse per window.
  - Outputs are spaced at least 2 cycles apart within a row.
  - There are no outputs during even rows.
- `o_data_last` and `o_frame_err` are registered and aligned 1 cycle after the offending or last input beat.
- There is no ready signal. The block accepts one beat per cycle, sustained.
- Back-to-back frames: a beat at (0,0) of the next frame may arrive in the cycle immediately after `i_data_last`.

## Test plan
- Ramp frame with DW=4, DH=4, `i_data` = row*4+col, continuous valid.
  - Outputs are 5, 7, 13, 15.
  - `o_data_last` is set only with 15.
  - Each output arrives 1 cycle after its input beats (1,1), (1,3), (3,1), (3,3).
- Signed data:
  - Window {-128, -3, -7, -100} -> -3 with RL=0, and 0 with RL=1.
  - Window {127, -128, 0, 5} -> 127.
- Random `i_data_valid` gaps (about 50% duty) on the full 72x128 frame.
  - The output stream is bit-identical to the gap-free run.
  - Exactly 2304 outputs.
  - `o_frame_err` never asserts.
- Framing errors:
  - `i_data_last` at (1,1) -> that output is emitted with `o_data_last`=0, plus a 1-cycle `o_frame_err`. The next beat is treated as (0,0).
  - Omitted `i_data_last` -> `o_frame_err` pulses at the frame end.
- `i_rst` pulsed at row 37, col 10, followed by a fresh full frame -> 2304 correct outputs with no stale `lbuf` influence.
- Two back-to-back frames with no idle cycle -> 4608 outputs, with `o_data_last` set on outputs 2304 and 4608.
